// File: rtl/obstacle_scheduler_if.sv
// Handshake bundle between the obstacle scheduler and its environment:
// game control and sprite status in, launch pulses and status out.
interface obstacle_if;
  logic        step;
  logic        run;
  logic        fin_s;
  logic        fin_b;
  logic        start_s;
  logic        start_b;
  logic        kind;
  logic [15:0] spawn_cnt;
  logic        err;

  modport master (
    output step, run, fin_s, fin_b,
    input  start_s, start_b, kind, spawn_cnt, err
  );

  modport slave (
    input  step, run, fin_s, fin_b,
    output start_s, start_b, kind, spawn_cnt, err
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Cactus launch scheduler: LFSR-randomised gap in scroll steps, picks a free
// sprite, issues a one-cycle start pulse and counts launches.
module obstacle_scheduler #(
  parameter int unsigned GAP_MIN     = 120,
  parameter logic [7:0]  GAP_MASK    = 8'h7F,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      clrn,
  obstacle_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GAP, PICK, FIRE, WAIT_ACK} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [7:0]  ACK_LAST  = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_gap_cnt, w_gap_nxt;
  logic [7:0]  r_ack_cnt, w_ack_nxt;
  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [15:0] r_spawn_cnt, w_spawn_nxt;
  logic        r_kind, w_kind_nxt;
  logic        r_start_s, w_start_s_nxt;
  logic        r_start_b, w_start_b_nxt;
  logic        r_err, w_err_nxt;
  logic [9:0]  w_gap_val;
  logic        w_pref, w_fin_pref, w_fin_other, w_fin_kind;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_lfsr_nxt  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign w_gap_val   = 10'(GAP_MIN) + {2'b00, r_lfsr[7:0] & GAP_MASK};
  assign w_pref      = r_lfsr[0];
  assign w_fin_pref  = w_pref ? bus.fin_b : bus.fin_s;
  assign w_fin_other = w_pref ? bus.fin_s : bus.fin_b;
  assign w_fin_kind  = r_kind ? bus.fin_b : bus.fin_s;

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap_cnt;
    w_ack_nxt     = r_ack_cnt;
    w_kind_nxt    = r_kind;
    w_spawn_nxt   = r_spawn_cnt;
    w_err_nxt     = r_err;
    w_start_s_nxt = 1'b0;
    w_start_b_nxt = 1'b0;
    // Losing run overrides everything, including a launch decided this cycle.
    if (r_state != IDLE && !bus.run) begin
      w_state_nxt = IDLE;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.run) begin
            w_gap_nxt   = w_gap_val;
            w_spawn_nxt = '0;
            w_state_nxt = GAP;
          end
        end
        GAP: begin
          if (bus.step) begin
            if (r_gap_cnt <= 10'd1) begin
              w_gap_nxt   = '0;
              w_state_nxt = PICK;
            end else begin
              w_gap_nxt = r_gap_cnt - 10'd1;
            end
          end
        end
        PICK: begin
          // The pulse and count are registered here so they are visible in FIRE.
          if (w_fin_pref || w_fin_other) begin
            w_kind_nxt    = w_fin_pref ? w_pref : ~w_pref;
            w_start_b_nxt = w_fin_pref ? w_pref : ~w_pref;
            w_start_s_nxt = w_fin_pref ? ~w_pref : w_pref;
            w_spawn_nxt   = sat_inc16(r_spawn_cnt);
            w_state_nxt   = FIRE;
          end
        end
        FIRE: begin
          w_ack_nxt   = '0;
          w_state_nxt = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!w_fin_kind) begin
            w_gap_nxt   = w_gap_val;
            w_state_nxt = GAP;
          end else begin
            w_ack_nxt = r_ack_cnt + 8'd1;
            if (r_ack_cnt == ACK_LAST) begin
              w_err_nxt   = 1'b1;
              w_gap_nxt   = w_gap_val;
              w_state_nxt = GAP;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= IDLE;
      r_gap_cnt   <= '0;
      r_ack_cnt   <= '0;
      r_lfsr      <= LFSR_SEED;
      r_spawn_cnt <= '0;
      r_kind      <= 1'b0;
      r_start_s   <= 1'b0;
      r_start_b   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_ack_cnt   <= w_ack_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_spawn_cnt <= w_spawn_nxt;
      r_kind      <= w_kind_nxt;
      r_start_s   <= w_start_s_nxt;
      r_start_b   <= w_start_b_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign bus.start_s   = r_start_s;
  assign bus.start_b   = r_start_b;
  assign bus.kind      = r_kind;
  assign bus.spawn_cnt = r_spawn_cnt;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: vector table for the fixed-gap case,
// hand sequences for busy sprites, ack timeout and abort, plus a long run.
module tb_obstacle_scheduler;
  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int checks   = 0;
  int failures = 0;

  localparam int N_LONG      = 250;
  localparam int LONG_BUDGET = 75000;

  obstacle_if if_det ();
  obstacle_if if_busy ();
  obstacle_if if_long ();

  obstacle_scheduler #(.GAP_MIN(5), .GAP_MASK(8'h00), .LFSR_SEED(16'hACE1), .ACK_TIMEOUT(15))
    u_det (.clk(clk), .clrn(clrn), .bus(if_det));
  obstacle_scheduler #(.GAP_MIN(2), .GAP_MASK(8'h00), .LFSR_SEED(16'hACE1), .ACK_TIMEOUT(15))
    u_busy (.clk(clk), .clrn(clrn), .bus(if_busy));
  obstacle_scheduler #(.GAP_MIN(120), .GAP_MASK(8'h7F), .LFSR_SEED(16'hACE1), .ACK_TIMEOUT(15))
    u_long (.clk(clk), .clrn(clrn), .bus(if_long));

  always #5 clk = ~clk;

  typedef struct {
    logic        step;
    logic        run;
    logic        fin_s;
    logic        fin_b;
    logic        exp_pulse;
    logic [15:0] exp_spawn;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic rn, input logic fs, input logic fb,
                              input logic pl, input logic [15:0] sp, input logic er);
    vec_t v;
    v.step = st; v.run = rn; v.fin_s = fs; v.fin_b = fb;
    v.exp_pulse = pl; v.exp_spawn = sp; v.exp_err = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    int n, pulses, cyc, start_edge, g, spawns, overlap, kind_bad, busy_s, busy_b;
    logic st, pulse, prev;

    if_det.step = 0;  if_det.run = 0;  if_det.fin_s = 1;  if_det.fin_b = 1;
    if_busy.step = 0; if_busy.run = 0; if_busy.fin_s = 0; if_busy.fin_b = 0;
    if_long.step = 0; if_long.run = 0; if_long.fin_s = 1; if_long.fin_b = 1;

    // Reset held with run high and step toggling
    if_det.run = 1; if_long.run = 1;
    for (int i = 0; i < 4; i++) begin
      if_det.step = i[0]; if_long.step = i[0];
      tick();
      chk("rst_det_outs", {12'h0, if_det.start_s, if_det.start_b, if_det.kind, if_det.err, if_det.spawn_cnt}, 32'h0);
      chk("rst_long_outs", {12'h0, if_long.start_s, if_long.start_b, if_long.kind, if_long.err, if_long.spawn_cnt}, 32'h0);
    end
    if_det.run = 0; if_long.run = 0; if_det.step = 0; if_long.step = 0;
    #2 clrn = 1;
    tick();

    // Fixed gap of 5, step every third clk
    tbl.push_back(mk(0, 1, 1, 1, 0, 16'd0, 0));
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < 3; k++)
        tbl.push_back(mk(k == 2, 1, 1, 1, 0, 16'd0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 16'd1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'd1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'd1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 0, 0, 0, 16'd1, 0));
    foreach (tbl[i]) begin
      if_det.step = tbl[i].step; if_det.run = tbl[i].run;
      if_det.fin_s = tbl[i].fin_s; if_det.fin_b = tbl[i].fin_b;
      tick();
      chk($sformatf("det_pulse[%0d]", i), {31'h0, if_det.start_s | if_det.start_b}, {31'h0, tbl[i].exp_pulse});
      chk($sformatf("det_overlap[%0d]", i), {31'h0, if_det.start_s & if_det.start_b}, 32'h0);
      chk($sformatf("det_spawn[%0d]", i), {16'h0, if_det.spawn_cnt}, {16'h0, tbl[i].exp_spawn});
      chk($sformatf("det_err[%0d]", i), {31'h0, if_det.err}, {31'h0, tbl[i].exp_err});
    end

    // Asynchronous reset mid-GAP takes effect without a clock edge
    #2 clrn = 0;
    #1;
    chk("async_rst_spawn", {16'h0, if_det.spawn_cnt}, 32'h0);
    chk("async_rst_flags", {28'h0, if_det.start_s, if_det.start_b, if_det.kind, if_det.err}, 32'h0);
    if_det.run = 0; if_det.step = 0;
    tick();
    #2 clrn = 1;
    tick();

    // Both sprites busy at gap expiry, big one frees after 10 clk
    if_busy.run = 1; if_busy.fin_s = 0; if_busy.fin_b = 0;
    tick();
    if_busy.step = 1;
    tick(); tick();
    if_busy.step = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if_busy.start_s || if_busy.start_b) pulses++;
    end
    chk("busy_no_pulse", pulses, 0);
    if_busy.fin_b = 1;
    tick();
    chk("busy_start_b", {31'h0, if_busy.start_b}, 32'h1);
    chk("busy_start_s", {31'h0, if_busy.start_s}, 32'h0);
    chk("busy_kind", {31'h0, if_busy.kind}, 32'h1);
    chk("busy_spawn", {16'h0, if_busy.spawn_cnt}, 32'h1);
    if_busy.fin_b = 0;
    tick();
    chk("busy_pulse_width", {31'h0, if_busy.start_b}, 32'h0);
    if_busy.run = 0;
    tick();

    // Acknowledge timeout: chosen sprite never reports busy
    if_det.run = 1; if_det.fin_s = 1; if_det.fin_b = 1; if_det.step = 1;
    tick();
    n = 0;
    do begin tick(); n++; end while (!(if_det.start_s || if_det.start_b) && n < 20);
    chk("to_first_latency", n, 6);
    for (int i = 0; i < 15; i++) tick();
    chk("to_err_before", {31'h0, if_det.err}, 32'h0);
    tick();
    chk("to_err_set", {31'h0, if_det.err}, 32'h1);
    n = 0;
    do begin tick(); n++; end while (!(if_det.start_s || if_det.start_b) && n < 20);
    chk("to_next_gap_latency", n, 6);
    chk("to_spawn2", {16'h0, if_det.spawn_cnt}, 32'd2);
    if_det.run = 0;
    tick();
    chk("to_err_hold_idle", {31'h0, if_det.err}, 32'h1);
    if_det.run = 1;
    tick();
    chk("to_err_hold_rerun", {31'h0, if_det.err}, 32'h1);
    chk("to_spawn_cleared", {16'h0, if_det.spawn_cnt}, 32'h0);
    if_det.run = 0; if_det.step = 0;
    tick();

    // Abort: run drops on the cycle PICK would accept
    if_det.run = 1; if_det.step = 1; if_det.fin_s = 1; if_det.fin_b = 1;
    tick();
    n = 0;
    do begin tick(); n++; end while (!(if_det.start_s || if_det.start_b) && n < 20);
    chk("ab_first_latency", n, 6);
    if_det.fin_s = 0; if_det.fin_b = 0; if_det.step = 0;
    tick(); tick();
    if_det.fin_s = 1; if_det.fin_b = 1; if_det.step = 1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_det.start_s || if_det.start_b) pulses++;
    end
    chk("ab_no_early_pulse", pulses, 0);
    if_det.run = 0; if_det.step = 0;
    tick();
    chk("ab_suppressed", {30'h0, if_det.start_s, if_det.start_b}, 32'h0);
    chk("ab_spawn_hold", {16'h0, if_det.spawn_cnt}, 32'h1);
    tick();
    chk("ab_idle_quiet", {30'h0, if_det.start_s, if_det.start_b}, 32'h0);
    if_det.run = 1;
    tick();
    chk("ab_rerun_spawn", {16'h0, if_det.spawn_cnt}, 32'h0);
    chk("ab_rerun_nopulse", {30'h0, if_det.start_s, if_det.start_b}, 32'h0);
    if_det.run = 0;
    tick();

    // Long run with random step and sprite busy times shorter than any gap
    if_long.run = 1; if_long.step = 0; if_long.fin_s = 1; if_long.fin_b = 1;
    tick();
    cyc = 0; start_edge = 1; g = 0; spawns = 0; overlap = 0; kind_bad = 0;
    busy_s = 0; busy_b = 0; prev = 0;
    while (spawns < N_LONG && cyc < LONG_BUDGET) begin
      if_long.step  = ($urandom_range(0, 7) != 0);
      if_long.fin_s = (busy_s == 0);
      if_long.fin_b = (busy_b == 0);
      st = if_long.step;
      tick();
      cyc++;
      if (busy_s > 0) busy_s--;
      if (busy_b > 0) busy_b--;
      pulse = if_long.start_s | if_long.start_b;
      if (if_long.start_s && if_long.start_b) overlap++;
      if (pulse && prev) overlap++;
      if (pulse) begin
        checks++;
        if (g < 120 || g > 247) begin
          failures++;
          $display("FAIL long_gap spawn=%0d actual=%0d required=120..247", spawns, g);
        end
        if (if_long.kind !== if_long.start_b) kind_bad++;
        if (if_long.start_s) busy_s = $urandom_range(2, 100);
        else busy_b = $urandom_range(2, 100);
        spawns++;
        g = 0;
        start_edge = cyc + 3;
      end else if (cyc >= start_edge && st) begin
        g++;
      end
      prev = pulse;
    end
    chk("long_spawns_reached", spawns, N_LONG);
    chk("long_spawn_cnt", {16'h0, if_long.spawn_cnt}, N_LONG);
    chk("long_overlap", overlap, 0);
    chk("long_kind", kind_bad, 0);
    chk("long_err", {31'h0, if_long.err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
